regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//   Parametrised multi-port register file, successor to the 2R/1W regfile.
//   Adds: configurable width/depth/port counts, multiple write ports with fixed priority,
//   optional same-cycle write-to-read bypass, and a hardware clear sweep after reset.
//   Sits in the decode/writeback boundary of the core; reads feed operand latches.
// PARAMETERS
//   DATA_W    32  data width of each entry
//   ADDR_W    5   address width; DEPTH = 2**ADDR_W entries
//   NUM_RD    2   number of read ports (1..4)
//   NUM_WR    2   number of write ports (1..2); higher index has priority
//   BYPASS    1   1 = a same-cycle write is forwarded to matching reads; 0 = reads see old value
//   ZERO_REG  1   1 = entry 0 is hardwired zero (writes dropped, reads return 0)
// PORTS
//   clk           in   1               clock, all state updates on posedge
//   rst           in   1               synchronous, active-high reset
//   wr_en         in   NUM_WR          per-port write enable
//   wr_addr       in   NUM_WR*ADDR_W   packed write addresses, port p at [p*ADDR_W +: ADDR_W]
//   wr_data       in   NUM_WR*DATA_W   packed write data, port p at [p*DATA_W +: DATA_W]
//   rd_en         in   NUM_RD          per-port read enable
//   rd_addr       in   NUM_RD*ADDR_W   packed read addresses
//   rd_data       out  NUM_RD*DATA_W   packed read data (combinational)
//   ready         out  1               1 = clear sweep done, array usable
//   wr_conflict   out  1               registered pulse: previous cycle had a write-address collision
// BEHAVIOUR
//   - Reset: while rst=1 -> state=CLEAR, clr_ptr=0, ready=0, wr_conflict=0; no entries written.
//   - FSM CLEAR: each cycle after rst deasserts, regs[clr_ptr]<=0, clr_ptr++ (ADDR_W bits);
//     when clr_ptr==DEPTH-1 is cleared, next state READY. Sweep takes exactly DEPTH cycles;
//     ready rises on the cycle after the last clear write. rst mid-sweep restarts from ptr 0.
//   - FSM READY: terminal until rst. ready=1.
//   - Writes: only in READY. Port p writes regs[wr_addr_p]<=wr_data_p at posedge when wr_en[p].
//     In CLEAR, all writes are dropped silently (no retry, no flag).
//   - Write collision: two enabled ports, same address -> highest-index port's data is stored;
//     wr_conflict=1 on the following cycle for one cycle. Collision on address 0 with
//     ZERO_REG=1 is not flagged. wr_conflict only evaluated in READY.
//   - ZERO_REG=1: writes to address 0 ignored; reads of address 0 return 0 (also not bypassed).
//   - Reads (combinational): rd_data_q = 0 if !rd_en[q] or !ready; else if BYPASS and any
//     enabled write port matches rd_addr_q (nonzero when ZERO_REG) -> that port's wr_data
//     (highest index wins); else regs[rd_addr_q]. No read-side latency.
//   - Unwritten entries after sweep read 0; no X may reach rd_data after ready=1.
//   - No entry retains its value across rst; rst always forces a full sweep.
// TESTING
//   1 Reset/sweep: rst 2 cycles, release -> ready=0 for exactly 32 cycles, then 1; read all
//     32 addrs -> 0.
//   2 Basic W/R: write 0xDEADBEEF to r5 via port 0, next cycle read r5 on both ports ->
//     0xDEADBEEF; rd_en=0 -> 0.
//   3 Bypass: same cycle wr port0 r7=0x1234, rd r7 -> 0x1234 (BYPASS=1); old value
//     (BYPASS=0 build).
//   4 Collision: port0 r3=0x1111, port1 r3=0x2222 same cycle -> r3=0x2222, wr_conflict=1
//     next cycle only; bypass read same cycle -> 0x2222.
//   5 Zero reg: write r0=0xFFFFFFFF -> read r0=0; both ports write r0 -> wr_conflict stays 0.
//   6 Reset mid-sweep + dropped writes: rst at sweep cycle 10, release -> full 32-cycle sweep
//     again; write r4=0xA during sweep -> r4 reads 0 after ready.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with fixed-priority write
// ports, optional same-cycle write-to-read bypass and a post-reset clear sweep.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_WR-1:0]          wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]   wr_data,
  input  logic [NUM_RD-1:0]          rd_en,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic                       ready,
  output logic                       wr_conflict
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   clr_ptr, clr_ptr_nxt;
  logic                conflict_nxt;
  logic [NUM_WR-1:0]   wr_live;
  logic [DATA_W-1:0]   regs [DEPTH];

  assign ready = (state == READY);

  // Qualify each write port: enabled, and not aimed at the hardwired zero entry.
  always_comb begin
    // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    wr_live = '0;
    for (int p = 0; p < NUM_WR; p++) begin
      wr_live[p] = wr_en[p] &&
                   !((ZERO_REG != 0) && (wr_addr[p*ADDR_W +: ADDR_W] == '0));
    end
  end

  // Detect two live write ports targeting the same entry (only meaningful in READY).
  always_comb begin
    conflict_nxt = 1'b0;
    if (state == READY) begin
      for (int i = 0; i < NUM_WR; i++) begin
        for (int j = i + 1; j < NUM_WR; j++) begin
          if (wr_live[i] && wr_live[j] &&
              (wr_addr[i*ADDR_W +: ADDR_W] == wr_addr[j*ADDR_W +: ADDR_W])) begin
            conflict_nxt = 1'b1;
          end
        end
      end
    end
  end

  // Next-state logic: sweep every entry once, then sit in READY until reset.
  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    case (state)
      CLEAR: begin
        clr_ptr_nxt = clr_ptr + ADDR_W'(1);
        if (&clr_ptr) state_nxt = READY;
      end
      READY:   state_nxt = READY;
      default: state_nxt = CLEAR;
    endcase
  end

  // Control registers with synchronous reset; reset always restarts the sweep.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    if (rst) begin
      state       <= CLEAR;
      clr_ptr     <= '0;
      wr_conflict <= 1'b0;
    end else begin
      state       <= state_nxt;
      clr_ptr     <= clr_ptr_nxt;
      wr_conflict <= conflict_nxt;
    end
  end

  // Storage array: cleared one entry per cycle by the sweep, then written by the ports.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset term; the sweep clears it, keeping it mappable to plain RAM.
    if (!rst) begin
      if (state == CLEAR) begin
        regs[clr_ptr] <= '0;
      end else begin
        // Later (higher-index) ports overwrite earlier ones, giving fixed priority.
        for (int p = 0; p < NUM_WR; p++) begin
          if (wr_live[p]) regs[wr_addr[p*ADDR_W +: ADDR_W]] <= wr_data[p*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Combinational read ports with optional forwarding of same-cycle writes.
  always_comb begin
    rd_data = '0;
    for (int q = 0; q < NUM_RD; q++) begin
      if (rd_en[q] && ready) begin
        rd_data[q*DATA_W +: DATA_W] = regs[rd_addr[q*ADDR_W +: ADDR_W]];
        if (BYPASS != 0) begin
          for (int p = 0; p < NUM_WR; p++) begin
            if (wr_live[p] && (wr_addr[p*ADDR_W +: ADDR_W] == rd_addr[q*ADDR_W +: ADDR_W])) begin
              rd_data[q*DATA_W +: DATA_W] = wr_data[p*DATA_W +: DATA_W];
            end
          end
        end
        if ((ZERO_REG != 0) && (rd_addr[q*ADDR_W +: ADDR_W] == '0)) begin
          rd_data[q*DATA_W +: DATA_W] = '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: checks a bypassing and a non-bypassing regfile_mp (shared stimulus)
// with directed vector tables, reset/sweep sequences and randomized traffic.
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clk;
  logic          rst;
  logic [1:0]    wr_en;
  logic [2*AW-1:0] wr_addr;
  logic [2*DW-1:0] wr_data;
  logic [1:0]    rd_en;
  logic [2*AW-1:0] rd_addr;
  logic [2*DW-1:0] rd_data, rd_data_nb;
  logic          ready, ready_nb;
  logic          wr_conflict, wr_conflict_nb;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [DW-1:0] m_mem [DEPTH];
  int            m_cnt;
  logic          m_conf;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(2), .NUM_WR(2), .BYPASS(1), .ZERO_REG(1)) u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .ready(ready), .wr_conflict(wr_conflict)
  );

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(2), .NUM_WR(2), .BYPASS(0), .ZERO_REG(1)) u_dut_nb (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_nb), .ready(ready_nb),
    .wr_conflict(wr_conflict_nb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [1:0]    we;
    logic [AW-1:0] wa0;
    logic [DW-1:0] wd0;
    logic [AW-1:0] wa1;
    logic [DW-1:0] wd1;
    logic [1:0]    re;
    logic [AW-1:0] ra0;
    logic [AW-1:0] ra1;
    logic [DW-1:0] exp_rd0;
    logic [DW-1:0] exp_rd1;
    logic [DW-1:0] exp_nb0;
    logic          exp_conf;
  } vec_t;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] we, input logic [AW-1:0] wa0, input logic [DW-1:0] wd0,
                       input logic [AW-1:0] wa1, input logic [DW-1:0] wd1,
                       input logic [1:0] re, input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
    wr_en   = we;
    wr_addr = {wa1, wa0};
    wr_data = {wd1, wd0};
    rd_en   = re;
    rd_addr = {ra1, ra0};
  endtask

  task automatic idle();
    drive(2'b00, '0, '0, '0, '0, 2'b00, '0, '0);
  endtask

  // Model: reset wipes contents and restarts a DEPTH-cycle blackout; writes only when ready.
  task automatic model_update();
    logic rdy;
    rdy = (m_cnt >= DEPTH);
    if (rst) begin
      m_cnt  = 0;
      m_conf = 1'b0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    end else begin
      m_conf = rdy && (wr_en == 2'b11) && (wr_addr[0 +: AW] == wr_addr[AW +: AW]) &&
               (wr_addr[0 +: AW] != '0);
      if (rdy) begin
        for (int p = 0; p < 2; p++) begin
          if (wr_en[p] && wr_addr[p*AW +: AW] != '0) m_mem[wr_addr[p*AW +: AW]] = wr_data[p*DW +: DW];
        end
      end else begin
        m_cnt++;
      end
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input int q, input bit byp);
    logic [AW-1:0] a;
    a = rd_addr[q*AW +: AW];
    if (!rd_en[q] || m_cnt < DEPTH || a == '0) return '0;
    if (byp) begin
      for (int p = 1; p >= 0; p--) begin
        if (wr_en[p] && wr_addr[p*AW +: AW] == a) return wr_data[p*DW +: DW];
      end
    end
    return m_mem[a];
  endfunction

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    #1;
  endtask

  // Counts clock edges from now until ready rises, bounded.
  task automatic count_sweep(output int n);
    n = 0;
    while (ready !== 1'b1 && n < 4 * DEPTH) begin
      tick();
      n++;
    end
  endtask

  vec_t vecs[$];
  int   n;

  initial begin
    rst = 1'b1;
    idle();
    m_cnt  = 0;
    m_conf = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

    // 1: reset and sweep timing, then every entry reads zero
    tick();
    tick();
    check("reset_ready", ready, 0);
    check("reset_conflict", wr_conflict, 0);
    rst = 1'b0;
    count_sweep(n);
    check("sweep_cycles", n, DEPTH);
    check("sweep_ready_nb", ready_nb, 1);
    for (int a = 0; a < DEPTH; a += 2) begin
      drive(2'b00, '0, '0, '0, '0, 2'b11, AW'(a), AW'(a + 1));
      #1;
      check($sformatf("clear_rd_r%0d", a), rd_data[0 +: DW], 0);
      check($sformatf("clear_rd_r%0d", a + 1), rd_data[DW +: DW], 0);
    end

    // 2-5: directed vector table (basic write/read, bypass, collision, zero register)
    //            we     wa0 wd0           wa1 wd1           re     ra0 ra1  rd0           rd1           nb0           conf
    vecs.push_back('{2'b01, 5,  32'hDEADBEEF, 0,  0,            2'b11, 5,  5,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        0});
    vecs.push_back('{2'b00, 0,  0,            0,  0,            2'b11, 5,  5,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 0});
    vecs.push_back('{2'b00, 0,  0,            0,  0,            2'b00, 5,  5,  32'h0,        32'h0,        32'h0,        0});
    vecs.push_back('{2'b01, 7,  32'h1234,     0,  0,            2'b11, 7,  5,  32'h1234,     32'hDEADBEEF, 32'h0,        0});
    vecs.push_back('{2'b00, 0,  0,            0,  0,            2'b11, 7,  7,  32'h1234,     32'h1234,     32'h1234,     0});
    vecs.push_back('{2'b11, 3,  32'h1111,     3,  32'h2222,     2'b11, 3,  3,  32'h2222,     32'h2222,     32'h0,        0});
    vecs.push_back('{2'b00, 0,  0,            0,  0,            2'b11, 3,  3,  32'h2222,     32'h2222,     32'h2222,     1});
    vecs.push_back('{2'b00, 0,  0,            0,  0,            2'b11, 3,  3,  32'h2222,     32'h2222,     32'h2222,     0});
    vecs.push_back('{2'b01, 0,  32'hFFFFFFFF, 0,  0,            2'b11, 0,  0,  32'h0,        32'h0,        32'h0,        0});
    vecs.push_back('{2'b00, 0,  0,            0,  0,            2'b11, 0,  0,  32'h0,        32'h0,        32'h0,        0});
    vecs.push_back('{2'b11, 0,  32'hF0F0F0F0, 0,  32'h0F0F0F0F, 2'b11, 0,  0,  32'h0,        32'h0,        32'h0,        0});
    vecs.push_back('{2'b00, 0,  0,            0,  0,            2'b11, 0,  7,  32'h0,        32'h1234,     32'h0,        0});
    vecs.push_back('{2'b11, 10, 32'h66,       9,  32'h55,       2'b11, 9,  10, 32'h55,       32'h66,       32'h0,        0});
    vecs.push_back('{2'b00, 0,  0,            0,  0,            2'b11, 9,  10, 32'h55,       32'h66,       32'h55,       0});
    vecs.push_back('{2'b01, 12, 32'hABCD,     0,  0,            2'b10, 12, 12, 32'h0,        32'hABCD,     32'h0,        0});
    foreach (vecs[i]) begin
      drive(vecs[i].we, vecs[i].wa0, vecs[i].wd0, vecs[i].wa1, vecs[i].wd1,
            vecs[i].re, vecs[i].ra0, vecs[i].ra1);
      #1;
      check($sformatf("vec%0d_rd0", i), rd_data[0 +: DW], vecs[i].exp_rd0);
      check($sformatf("vec%0d_rd1", i), rd_data[DW +: DW], vecs[i].exp_rd1);
      check($sformatf("vec%0d_nb_rd0", i), rd_data_nb[0 +: DW], vecs[i].exp_nb0);
      check($sformatf("vec%0d_conflict", i), wr_conflict, vecs[i].exp_conf);
      tick();
    end

    // 6: stored value lost on reset, reset mid-sweep restarts, sweep-time writes dropped
    drive(2'b01, 4, 32'h77, 0, 0, 2'b00, 0, 0);
    tick();
    idle();
    rd_en = 2'b01;
    rd_addr = {AW'(0), AW'(4)};
    #1;
    check("pre_reset_r4", rd_data[0 +: DW], 32'h77);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("mid_sweep_ready", ready, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(2'b11, 4, 32'hA, 4, 32'hB, 2'b11, 4, 4);
    count_sweep(n);
    check("resweep_cycles", n, DEPTH);
    idle();
    rd_en = 2'b11;
    rd_addr = {AW'(4), AW'(4)};
    #1;
    check("dropped_write_r4", rd_data[0 +: DW], 0);
    check("dropped_write_r4_nb", rd_data_nb[DW +: DW], 0);
    check("sweep_no_conflict", wr_conflict, 0);
    tick();
    check("sweep_no_conflict_next", wr_conflict, 0);

    // Randomized traffic against the reference model, with occasional resets
    for (int it = 0; it < 600; it++) begin
      rst = ($urandom_range(0, 199) == 0);
      drive(2'($urandom), AW'($urandom_range(0, 7)), $urandom, AW'($urandom_range(0, 7)), $urandom,
            2'($urandom), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
      #1;
      check("rand_rd0", rd_data[0 +: DW], exp_rd(0, 1'b1));
      check("rand_rd1", rd_data[DW +: DW], exp_rd(1, 1'b1));
      check("rand_nb_rd0", rd_data_nb[0 +: DW], exp_rd(0, 1'b0));
      check("rand_nb_rd1", rd_data_nb[DW +: DW], exp_rd(1, 1'b0));
      check("rand_ready", ready, m_cnt >= DEPTH);
      check("rand_conflict", wr_conflict, m_conf);
      check("rand_conflict_nb", wr_conflict_nb, m_conf);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
